// File: rtl/i2c_reg_arbiter.sv
// Register bank shared between an i2c slave port (writes never stall) and NUM_REQ
// round-robin local requesters. Define I2C_LOCK_EN to hold off local writes while i2c_busy.
module i2c_reg_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16,
   parameter int REG_COUNT  = 16,
   parameter int NUM_REQ    = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          i2c_write_en,
   input  logic [ADDR_WIDTH-1:0]         i2c_reg_addr,
   input  logic [DATA_WIDTH-1:0]         i2c_wdata,
   output logic [DATA_WIDTH-1:0]         i2c_rdata,
   input  logic                          i2c_busy,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ-1:0]            we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
   output logic [NUM_REQ-1:0]            gnt,
   output logic [DATA_WIDTH-1:0]         rdata,
   output logic                          rvalid,
   output logic                          err
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int IDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

`ifdef I2C_LOCK_EN
   localparam logic LOCK_EN = 1'b1;
`else
   localparam logic LOCK_EN = 1'b0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

   state_t                  state, state_next;
   logic [DATA_WIDTH-1:0]   bank [REG_COUNT];
   logic [PTR_W-1:0]        ptr, idx, sel, cand;
   logic                    found;
   logic [NUM_REQ-1:0]      eligible;
   logic                    lat_we;
   logic [ADDR_WIDTH-1:0]   lat_addr;
   logic [DATA_WIDTH-1:0]   lat_wdata;
   logic                    i2c_in_range, lat_in_range;
   logic [IDX_W-1:0]        i2c_idx, lat_idx;

   assign i2c_in_range = 32'(i2c_reg_addr) < 32'(REG_COUNT);
   assign lat_in_range = 32'(lat_addr) < 32'(REG_COUNT);
   assign i2c_idx      = i2c_reg_addr[IDX_W-1:0];
   assign lat_idx      = lat_addr[IDX_W-1:0];

   // Local writes are masked only in S_IDLE; an access already latched still completes.
   assign eligible = req & ~(we & {NUM_REQ{i2c_busy & LOCK_EN}});

   always_comb begin
      found = 1'b0;
      sel   = '0;
      cand  = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = PTR_W'((32'(ptr) + k) % 32'(NUM_REQ));
         if (!found && eligible[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      gnt        = '0;
      rvalid     = 1'b0;
      err        = 1'b0;
      case (state)
         S_IDLE:   if (found) state_next = S_ACCESS;
         S_ACCESS: if (!i2c_write_en) state_next = S_RESP;
         S_RESP: begin
            state_next = S_IDLE;
            gnt        = NUM_REQ'(1) << idx;
            rvalid     = 1'b1;
            err        = !lat_in_range;
         end
         default:  state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bank      <= '{default: '0};
         ptr       <= '0;
         idx       <= '0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         rdata     <= '0;
         i2c_rdata <= '0;
      end else begin
         i2c_rdata <= i2c_in_range ? bank[i2c_idx] : '0;
         if (i2c_write_en && i2c_in_range)
            bank[i2c_idx] <= i2c_wdata;
         if (state == S_IDLE && found) begin
            idx       <= sel;
            lat_we    <= we[sel];
            lat_addr  <= addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
            lat_wdata <= wdata[sel*DATA_WIDTH +: DATA_WIDTH];
         end
         // The stall on i2c_write_en keeps the local bank write off the i2c write edge.
         if (state == S_ACCESS && !i2c_write_en) begin
            ptr <= (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
            if (lat_we) begin
               if (lat_in_range) bank[lat_idx] <= lat_wdata;
            end else begin
               rdata <= lat_in_range ? bank[lat_idx] : '0;
            end
         end
      end
   end

endmodule
